// File: rtl/imm_extend_stage_if.sv
// Handshake bundle between the IF/ID side and the ID/EX side of the immediate stage.
// The master drives instructions and consumes immediates; the slave is the stage itself.
interface imm_extend_stage_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_fmt;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_imm, out_fmt
  );
endinterface

// File: rtl/imm_extend_stage.sv
// LEGv8 immediate extraction: decodes the format, extends/scales the immediate and
// registers it into a 2-entry FIFO with valid/ready on both sides plus flush.
module imm_extend_stage #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned SHIFT_BRANCH = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  imm_extend_stage_if.slave  bus
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtD    = 3'd1;
  localparam logic [2:0] FmtI    = 3'd2;
  localparam logic [2:0] FmtCb   = 3'd3;
  localparam logic [2:0] FmtB    = 3'd4;
  localparam logic [2:0] FmtIw   = 3'd5;

  logic [31:0]       instr;
  logic [DATA_W-1:0] dec_imm;
  logic [2:0]        dec_fmt;

  assign instr = bus.in_instr;

  // Priority decode: B is tested first because its opcode only spans bits 30:26.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FmtNone;
    if (instr[30:26] == 5'b00101) begin
      dec_fmt = FmtB;
      dec_imm = {{(DATA_W-26){instr[25]}}, instr[25:0]};
      if (SHIFT_BRANCH != 0) dec_imm = dec_imm << 2;
    end else if (instr[31:24] inside {8'hB4, 8'hB5, 8'h54}) begin
      dec_fmt = FmtCb;
      dec_imm = {{(DATA_W-19){instr[23]}}, instr[23:5]};
      if (SHIFT_BRANCH != 0) dec_imm = dec_imm << 2;
    end else if (instr[31:24] == 8'hF8) begin
      dec_fmt = FmtD;
      dec_imm = {{(DATA_W-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:22] inside {10'h244, 10'h2C4, 10'h344, 10'h3C4,
                                      10'h248, 10'h2C8, 10'h348}) begin
      dec_fmt = FmtI;
      dec_imm = DATA_W'(instr[21:10]);
    end else if (instr[31:23] inside {9'h1A5, 9'h1E5}) begin
      dec_fmt = FmtIw;
      // Shift in DATA_W context so anything moved past the top is dropped.
      dec_imm = DATA_W'(instr[20:5]) << {instr[22:21], 4'b0000};
    end
  end

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
  logic [2:0]        head_fmt_q, head_fmt_d, tail_fmt_q, tail_fmt_d;
  logic              push, pop;

  assign bus.in_ready  = ~count_q[1];
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_imm   = head_imm_q;
  assign bus.out_fmt   = head_fmt_q;

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  // Head register is the output; it is only overwritten by a newer entry, so an
  // emptied buffer keeps showing the last popped value.
  always_comb begin
    count_d    = count_q;
    head_imm_d = head_imm_q;
    head_fmt_d = head_fmt_q;
    tail_imm_d = tail_imm_q;
    tail_fmt_d = tail_fmt_q;
    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && count_q == 2'd2) begin
        head_imm_d = tail_imm_q;
        head_fmt_d = tail_fmt_q;
      end
      if (push) begin
        if (count_q == 2'd0 || pop) begin
          head_imm_d = dec_imm;
          head_fmt_d = dec_fmt;
        end else begin
          tail_imm_d = dec_imm;
          tail_fmt_d = dec_fmt;
        end
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= 2'd0;
      head_imm_q <= '0;
      head_fmt_q <= FmtNone;
      tail_imm_q <= '0;
      tail_fmt_q <= FmtNone;
    end else begin
      count_q    <= count_d;
      head_imm_q <= head_imm_d;
      head_fmt_q <= head_fmt_d;
      tail_imm_q <= tail_imm_d;
      tail_fmt_q <= tail_fmt_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: directed cases followed by random traffic, with scaled and
// unscaled instances fed identically and checked against a queue-based reference.
module tb_imm_extend_stage;
  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  imm_extend_stage_if #(.DATA_W(DW)) bus1 ();
  imm_extend_stage_if #(.DATA_W(DW)) bus0 ();

  imm_extend_stage #(.DATA_W(DW), .SHIFT_BRANCH(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  imm_extend_stage #(.DATA_W(DW), .SHIFT_BRANCH(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.in_instr  = bus1.in_instr;
  assign bus0.flush     = bus1.flush;
  assign bus0.out_ready = bus1.out_ready;

  function automatic ent_t ref_model(input logic [31:0] w, input bit sh);
    ent_t        e;
    longint      v;
    logic [7:0]  op8;
    logic [9:0]  op10;
    logic [8:0]  op9;
    op8   = w[31:24];
    op10  = w[31:22];
    op9   = w[31:23];
    e.imm = 64'd0;
    e.fmt = 3'd0;
    if (w[30:26] == 5'b00101) begin
      v = longint'($signed(w[25:0]));
      if (sh) v = v * 4;
      e.imm = v;
      e.fmt = 3'd4;
    end else if (op8 == 8'hB4 || op8 == 8'hB5 || op8 == 8'h54) begin
      v = longint'($signed(w[23:5]));
      if (sh) v = v * 4;
      e.imm = v;
      e.fmt = 3'd3;
    end else if (op8 == 8'hF8) begin
      v = longint'($signed(w[20:12]));
      e.imm = v;
      e.fmt = 3'd1;
    end else if (op10 == 10'h244 || op10 == 10'h2C4 || op10 == 10'h344 || op10 == 10'h3C4 ||
                 op10 == 10'h248 || op10 == 10'h2C8 || op10 == 10'h348) begin
      e.imm = 64'(w[21:10]);
      e.fmt = 3'd2;
    end else if (op9 == 9'h1A5 || op9 == 9'h1E5) begin
      e.imm = 64'(w[20:5]) * (64'd1 << (16 * int'(w[22:21])));
      e.fmt = 3'd5;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
    bus1.in_valid  = v;
    bus1.in_instr  = w;
    bus1.out_ready = r;
    bus1.flush     = f;
  endtask

  // Called just after a rising edge with inputs already set: checks outputs, then
  // advances the reference across the next edge.
  task automatic step(input string tag);
    bit push, pop;
    check({tag, "/valid1"}, 64'(bus1.out_valid), 64'(q1.size() != 0));
    check({tag, "/ready1"}, 64'(bus1.in_ready), 64'(q1.size() < 2));
    check({tag, "/valid0"}, 64'(bus0.out_valid), 64'(q0.size() != 0));
    if (q1.size() != 0) begin
      check({tag, "/imm1"}, bus1.out_imm, q1[0].imm);
      check({tag, "/fmt1"}, 64'(bus1.out_fmt), 64'(q1[0].fmt));
      check({tag, "/imm0"}, bus0.out_imm, q0[0].imm);
      check({tag, "/fmt0"}, 64'(bus0.out_fmt), 64'(q0[0].fmt));
    end
    push = bus1.in_valid && (q1.size() < 2) && !bus1.flush;
    pop  = (q1.size() != 0) && bus1.out_ready && !bus1.flush;
    @(posedge clk);
    if (bus1.flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (push) begin
        q1.push_back(ref_model(bus1.in_instr, 1'b1));
        q0.push_back(ref_model(bus1.in_instr, 1'b0));
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [9:0]  ilist[7];
    ilist = '{10'h244, 10'h2C4, 10'h344, 10'h3C4, 10'h248, 10'h2C8, 10'h348};
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[30:26] = 5'b00101;
      1: w[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'h54;
      2: w[31:24] = 8'hF8;
      3: w[31:22] = ilist[$urandom_range(0, 6)];
      4: w[31:23] = ($urandom_range(0, 1) != 0) ? 9'h1A5 : 9'h1E5;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "/valid"}, 64'(bus1.out_valid), 64'd0);
    check({tag, "/ready"}, 64'(bus1.in_ready), 64'd1);
    check({tag, "/imm"}, bus1.out_imm, 64'd0);
    check({tag, "/fmt"}, 64'(bus1.out_fmt), 64'd0);
    check({tag, "/imm0"}, bus0.out_imm, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed formats, back-to-back with the consumer always ready.
    drive(1'b1, 32'hF85FB022, 1'b1, 1'b0); step("ldur");
    check("ldur_const", bus1.out_imm, 64'hFFFFFFFFFFFFFFFB);
    drive(1'b1, 32'hB4FFFFC0, 1'b1, 1'b0); step("cbz");
    check("cbz_sh1", bus1.out_imm, 64'hFFFFFFFFFFFFFFF8);
    check("cbz_sh0", bus0.out_imm, 64'hFFFFFFFFFFFFFFFE);
    drive(1'b1, 32'hD2C24680, 1'b1, 1'b0); step("movz");
    check("movz_const", bus1.out_imm, 64'h0000123400000000);
    drive(1'b1, 32'h913FFC00, 1'b1, 1'b0); step("addi");
    check("addi_const", bus1.out_imm, 64'h0000000000000FFF);
    drive(1'b1, 32'h8B020020, 1'b1, 1'b0); step("add");
    check("add_fmt", 64'(bus1.out_fmt), 64'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0); step("drain");

    // Backpressure: third instruction held until space frees.
    drive(1'b1, 32'hF85FB022, 1'b0, 1'b0); step("bp0");
    drive(1'b1, 32'hB4FFFFC0, 1'b0, 1'b0); step("bp1");
    drive(1'b1, 32'hD2C24680, 1'b0, 1'b0); step("bp2");
    step("bp3");
    drive(1'b1, 32'hD2C24680, 1'b1, 1'b0); step("bp4");
    drive(1'b0, 32'd0, 1'b1, 1'b0); step("bp5");
    step("bp6");
    step("bp7");

    // Flush with a full buffer and a pending instruction.
    drive(1'b1, 32'h913FFC00, 1'b0, 1'b0); step("fl0");
    drive(1'b1, 32'h8B020020, 1'b0, 1'b0); step("fl1");
    drive(1'b1, 32'hF85FB022, 1'b0, 1'b1); step("fl2");
    drive(1'b0, 32'd0, 1'b1, 1'b0); step("fl3");
    step("fl4");

    // Asynchronous reset mid-cycle with two entries buffered.
    drive(1'b1, 32'hD2C24680, 1'b0, 1'b0); step("ar0");
    drive(1'b1, 32'hB4FFFFC0, 1'b0, 1'b0); step("ar1");
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    q1.delete();
    q0.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h913FFC00, 1'b1, 1'b0); step("ar2");
    drive(1'b0, 32'd0, 1'b1, 1'b0); step("ar3");
    step("ar4");

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
      step("rnd");
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step("end0");
    step("end1");
    step("end2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Parametrised, pipelined immediate-extraction stage for the pipelined LEGv8 datapath, superseding the single-format combinational sign extender. Each instruction word is decoded by format (D, I, CB, B, IW), and the format's immediate is extracted, sign- or zero-extended to `DATA_W`, and optionally scaled. The result is registered into a 2-entry output buffer with valid/ready handshakes on both sides. It sits between the IF/ID register and the ID/EX register, and supports stall (backpressure) and flush.

## Interface
- `DATA_W`, default 64: output immediate width; legal values are ≥ 32.
- `SHIFT_BRANCH`, default 1: when 1, B and CB offsets are shifted left by 2 (byte offset). When 0, they are left unscaled.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_instr` holds a valid instruction.
- `in_ready` output 1: stage can accept an instruction this cycle.
- `in_instr` input 32: instruction word.
- `flush` input 1: synchronous flush; discards all buffered and incoming entries.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: consumer takes the head entry this cycle.
- `out_imm` output `DATA_W`: extended immediate of the head entry.
- `out_fmt` output 3: format code of the head entry. 0 = NONE, 1 = D, 2 = I, 3 = CB, 4 = B, 5 = IW.

## Operation
Format decode is evaluated in priority order; the first match wins.
- **B:** `in_instr[30:26]` = 00101 (B/BL). The immediate is `in_instr[25:0]`, sign-extended.
- **CB:** `in_instr[31:24]` ∈ {10110100, 10110101, 01010100}. The immediate is `in_instr[23:5]`, sign-extended.
- **D:** `in_instr[31:24]` = 11111000. The immediate is `in_instr[20:12]`, sign-extended.
- **I:** `in_instr[31:22]` ∈ {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1011001000, 1101001000}. The immediate is `in_instr[21:10]`, zero-extended.
- **IW:** `in_instr[31:23]` ∈ {110100101, 111100101}.
  - The immediate is `in_instr[20:5]` zero-extended, then shifted left by 16·`in_instr[22:21]`.
  - The result is truncated to `DATA_W`, so bits shifted past `DATA_W` are lost.
- **NONE (anything else):** `out_imm` = 0.
- B/CB with `SHIFT_BRANCH`=1: the immediate is sign-extended first, then shifted left by 2, then truncated to `DATA_W`.

Buffering rules:
- The buffer is a 2-entry FIFO of {imm, fmt} with an occupancy `count` ∈ {0, 1, 2}.
- **Push:** `in_valid && in_ready && !flush`.
- **Pop:** `out_valid && out_ready && !flush`.
- **Readiness:** `in_ready` = (`count` < 2) and is driven from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- **Simultaneous push and pop at `count`=1:** `count` stays 1, the popped entry leaves, and the new entry becomes the head.
- **Push at `count`=2:** cannot occur, because `in_ready` is 0.
- **Flush:** sets `count` to 0 next cycle. It overrides any push or pop in the same cycle; the incoming instruction is dropped and no pop is counted.
- **Ordering:** entries leave in acceptance order. `out_imm` and `out_fmt` are held stable while `out_valid` is 1 and `out_ready` is 0.

## Timing
- **Reset:** on `reset_n`=0, immediately and independently of `clk`:
  - `count` = 0, `out_valid` = 0, `out_imm` = 0, `out_fmt` = 0.
  - `in_ready` = 1 while in reset and after release.
- **Latency:** an instruction accepted at edge N appears on `out_*`, with `out_valid`=1, after edge N (i.e. in cycle N+1).
- **Throughput:** one instruction per cycle while `out_ready` is held at 1.
- **Empty buffer:** `out_valid` = 0. `out_imm` and `out_fmt` retain the last popped values; consumers ignore them.
- **Reset during operation:** all buffered entries are lost. No partial entry is emitted after reset is released.

## Test plan
- **D format:** `in_instr`=0xF85FB022 (LDUR, imm9 = −5), `out_ready`=1 → one cycle later `out_valid`=1, `out_fmt`=1, `out_imm`=0xFFFFFFFFFFFFFFFB.
- **CB format, scaled:** `in_instr`=0xB4FFFFC0 (CBZ, imm19 = −2), `SHIFT_BRANCH`=1 → `out_fmt`=3, `out_imm`=0xFFFFFFFFFFFFFFF8. With `SHIFT_BRANCH`=0 → `out_imm`=0xFFFFFFFFFFFFFFFE.
- **IW and I formats, with NONE:**
  - `in_instr`=0xD2C24680 (MOVZ, hw=2, imm16 0x1234) → `out_fmt`=5, `out_imm`=0x0000123400000000.
  - Back-to-back `in_instr`=0x913FFC00 (ADDI, imm12 0xFFF) → `out_fmt`=2, `out_imm`=0x0000000000000FFF.
  - An R-format word (e.g. ADD, 0x8B020020) → `out_fmt`=0, `out_imm`=0.
- **Backpressure:** `out_ready`=0, present three valid instructions on consecutive cycles.
  - `in_ready` drops to 0 after two acceptances, and the third is held.
  - Raising `out_ready` drains the entries in order, one per cycle, with `out_*` stable while stalled.
- **Flush:** with `count`=2 and `in_valid`=1, assert `flush` for one cycle → next cycle `out_valid`=0 and `in_ready`=1. The flushed and incoming entries never appear.
- **Async reset:** drop `reset_n` mid-cycle with `count`=2 → `out_valid`, `out_imm` and `out_fmt` go to 0 before the next edge. After release, the first new instruction appears with 1-cycle latency.
